// File: rtl/leaf_switch.sv
// -----------------------------------------------------------------------------
// leaf_switch
//   Group-level leaf switch for the four GPUs (leaves 0..3) of one group plus
//   one uplink toward the group fabric. Each of the five inputs (leaf 0..3 and
//   the uplink at index 4) is buffered in its own FIFO. The FIFO heads are
//   routed on the 6-bit header in the top bits of the flit (group, leaf). Each
//   output is then arbitrated round-robin across the five heads.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   loc_in_data     : 4 x DATA_W flits from the NIs, leaf i at [i*DATA_W +: DATA_W]
//   loc_in_valid    : per-leaf 1-cycle flit pulse (written whenever space exists)
//   loc_in_ready    : per-leaf launch permission for the NI's next cycle
//   loc_out_data    : 4 x DATA_W flits to the NIs
//   loc_out_valid   : per-leaf 1-cycle pulse, no backpressure
//   up_out_data/valid/ready : uplink output, valid/ready with hold
//   up_in_data/valid/ready  : uplink input, valid/ready handshake
//   drop_cnt        : saturating count of dropped flits
// -----------------------------------------------------------------------------
module leaf_switch #(
    parameter logic [3:0] GROUP_ID = 4'd4,
    parameter int         DATA_W   = 16,
    parameter int         IN_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DATA_W-1:0]   loc_in_data,
    input  logic [3:0]            loc_in_valid,
    output logic [3:0]            loc_in_ready,
    output logic [4*DATA_W-1:0]   loc_out_data,
    output logic [3:0]            loc_out_valid,
    output logic [DATA_W-1:0]     up_out_data,
    output logic                  up_out_valid,
    input  logic                  up_out_ready,
    input  logic [DATA_W-1:0]     up_in_data,
    input  logic                  up_in_valid,
    output logic                  up_in_ready,
    output logic [7:0]            drop_cnt
);

    localparam int PW = $clog2(IN_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(IN_DEPTH);
    // Ready stays high while at least two slots are free, leaving one slot
    // for the flit the NI may launch in the cycle after ready falls.
    localparam logic [CW-1:0] SKID_CNT = CW'(IN_DEPTH - 2);

    // Round-robin pick over five requests, searching upward from start.
    function automatic logic [4:0] rr_pick(input logic [4:0] req, input logic [2:0] start);
        logic [4:0] gnt;
        logic       found;
        logic       hit;
        logic [2:0] idx;
        gnt   = 5'b00000;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idx      = 3'((32'(start) + 32'(k)) % 32'd5);
            hit      = !found && req[idx];
            gnt[idx] = gnt[idx] | hit;
            found    = found | hit;
        end
        return gnt;
    endfunction

    // One-hot to index encoder for a five-way grant.
    function automatic logic [2:0] enc5(input logic [4:0] gnt);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 5; k++) begin
            idx = idx | ({3{gnt[k]}} & 3'(k));
        end
        return idx;
    endfunction

    // Storage and state
    logic [DATA_W-1:0] mem_r     [5][IN_DEPTH];
    logic [PW-1:0]     wr_ptr_r  [5];
    logic [PW-1:0]     rd_ptr_r  [5];
    logic [CW-1:0]     count_r   [5];
    logic [2:0]        rr_ptr_r  [5];

    logic [3:0]            loc_in_ready_r;
    logic                  up_in_ready_r;
    logic [4*DATA_W-1:0]   loc_out_data_r;
    logic [3:0]            loc_out_valid_r;
    logic [DATA_W-1:0]     up_out_data_r;
    logic                  up_out_valid_r;
    logic [7:0]            drop_cnt_r;

    // Combinational routing / arbitration
    logic [DATA_W-1:0] in_data_s   [5];
    logic [DATA_W-1:0] head_s      [5];
    logic [4:0]        head_vld_s;
    logic [2:0]        dest_s      [5];
    logic              misroute_s;
    logic              up_grantable_s;
    logic [4:0]        req_s       [5];
    logic [4:0]        grant_s     [5];
    logic [4:0]        gnt_any_s;
    logic [2:0]        gnt_idx_s   [5];
    logic [DATA_W-1:0] gnt_data_s  [5];
    logic [4:0]        pop_s;
    logic [4:0]        push_s;
    logic [CW-1:0]     count_nxt_s [5];
    logic [2:0]        drop_inc_s;
    logic [8:0]        drop_sum_s;
    logic [7:0]        drop_nxt_s;

    // Decode every FIFO head into a destination output.
    always_comb begin
        for (int j = 0; j < 5; j++) begin
            if (j < 4) begin
                in_data_s[j] = loc_in_data[j*DATA_W +: DATA_W];
            end else begin
                in_data_s[j] = up_in_data;
            end
            head_s[j]     = mem_r[j][rd_ptr_r[j]];
            head_vld_s[j] = (count_r[j] != {CW{1'b0}});
            if (head_s[j][DATA_W-1 -: 4] == GROUP_ID) begin
                dest_s[j] = {1'b0, head_s[j][DATA_W-5 -: 2]};
            end else begin
                dest_s[j] = 3'd4;
            end
        end
        // An uplink flit for another group is never reflected back up.
        misroute_s = head_vld_s[4] && (dest_s[4] == 3'd4);
    end

    // Build per-output request vectors and arbitrate each output.
    always_comb begin
        // The uplink register may accept a new flit when empty or draining.
        up_grantable_s = !up_out_valid_r || up_out_ready;
        for (int o = 0; o < 5; o++) begin
            req_s[o] = 5'b00000;
            for (int j = 0; j < 5; j++) begin
                req_s[o][j] = head_vld_s[j] && (dest_s[j] == 3'(o)) && !((j == 4) && (o == 4));
            end
            if ((o == 4) && !up_grantable_s) begin
                req_s[o] = 5'b00000;
            end else begin
                req_s[o] = req_s[o];
            end
            grant_s[o]    = rr_pick(req_s[o], rr_ptr_r[o]);
            gnt_any_s[o]  = |grant_s[o];
            gnt_idx_s[o]  = enc5(grant_s[o]);
            gnt_data_s[o] = {DATA_W{1'b0}};
            for (int j = 0; j < 5; j++) begin
                gnt_data_s[o] = gnt_data_s[o] | ({DATA_W{grant_s[o][j]}} & head_s[j]);
            end
        end
    end

    // Derive push/pop per FIFO, next-state counts and the drop increment.
    always_comb begin
        drop_inc_s = 3'd0;
        for (int j = 0; j < 5; j++) begin
            pop_s[j] = 1'b0;
            for (int o = 0; o < 5; o++) begin
                pop_s[j] = pop_s[j] | grant_s[o][j];
            end
        end
        pop_s[4] = pop_s[4] | misroute_s;
        drop_inc_s = drop_inc_s + {2'b00, misroute_s};
        for (int i = 0; i < 4; i++) begin
            // A full FIFO still accepts a write when its head leaves this cycle.
            push_s[i]  = loc_in_valid[i] && ((count_r[i] != FULL_CNT) || pop_s[i]);
            drop_inc_s = drop_inc_s + {2'b00, (loc_in_valid[i] && !push_s[i])};
        end
        push_s[4] = up_in_valid && up_in_ready_r;
        for (int j = 0; j < 5; j++) begin
            count_nxt_s[j] = count_r[j] + CW'(push_s[j]) - CW'(pop_s[j]);
        end
        drop_sum_s = {1'b0, drop_cnt_r} + {6'd0, drop_inc_s};
        if (drop_sum_s[8]) begin
            drop_nxt_s = 8'hFF;
        end else begin
            drop_nxt_s = drop_sum_s[7:0];
        end
    end

    // FIFO storage write; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 5; j++) begin
            if (push_s[j]) begin
                mem_r[j][wr_ptr_r[j]] <= in_data_s[j];
            end
        end
    end

    // FIFO pointers, counts and the registered input-ready flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 5; j++) begin
                wr_ptr_r[j] <= {PW{1'b0}};
                rd_ptr_r[j] <= {PW{1'b0}};
                count_r[j]  <= {CW{1'b0}};
            end
            loc_in_ready_r <= 4'b1111;
            up_in_ready_r  <= 1'b1;
        end else begin
            for (int j = 0; j < 5; j++) begin
                if (push_s[j]) begin
                    wr_ptr_r[j] <= wr_ptr_r[j] + {{(PW-1){1'b0}}, 1'b1};
                end
                if (pop_s[j]) begin
                    rd_ptr_r[j] <= rd_ptr_r[j] + {{(PW-1){1'b0}}, 1'b1};
                end
                count_r[j] <= count_nxt_s[j];
            end
            for (int i = 0; i < 4; i++) begin
                loc_in_ready_r[i] <= (count_nxt_s[i] <= SKID_CNT);
            end
            up_in_ready_r <= (count_nxt_s[4] != FULL_CNT);
        end
    end

    // Round-robin pointers: next search starts one past the last grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < 5; o++) begin
                rr_ptr_r[o] <= 3'd0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (gnt_any_s[o]) begin
                    rr_ptr_r[o] <= (gnt_idx_s[o] == 3'd4) ? 3'd0 : (gnt_idx_s[o] + 3'd1);
                end
            end
        end
    end

    // Local output registers: one-cycle valid pulse per grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            loc_out_valid_r <= 4'b0000;
            loc_out_data_r  <= {(4*DATA_W){1'b0}};
        end else begin
            for (int o = 0; o < 4; o++) begin
                loc_out_valid_r[o] <= gnt_any_s[o];
                if (gnt_any_s[o]) begin
                    loc_out_data_r[o*DATA_W +: DATA_W] <= gnt_data_s[o];
                end
            end
        end
    end

    // Uplink output register: holds valid and data until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_out_valid_r <= 1'b0;
            up_out_data_r  <= {DATA_W{1'b0}};
        end else if (gnt_any_s[4]) begin
            up_out_valid_r <= 1'b1;
            up_out_data_r  <= gnt_data_s[4];
        end else if (up_out_ready) begin
            up_out_valid_r <= 1'b0;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_r <= 8'd0;
        end else begin
            drop_cnt_r <= drop_nxt_s;
        end
    end

    assign loc_in_ready  = loc_in_ready_r;
    assign up_in_ready   = up_in_ready_r;
    assign loc_out_data  = loc_out_data_r;
    assign loc_out_valid = loc_out_valid_r;
    assign up_out_data   = up_out_data_r;
    assign up_out_valid  = up_out_valid_r;
    assign drop_cnt      = drop_cnt_r;

endmodule

// File: doc/leaf_switch.md
Name: leaf_switch

Overview:
Group-level leaf switch. It sits at the router end of the network-interface link for the four GPUs of one group (leaf 0..3) and provides one uplink toward the group-level fabric. It buffers flits from each NI and from the uplink, then routes on the 6-bit header in bits [15:10] (bits [15:12] = group, bits [11:10] = leaf). It arbitrates each output round-robin, and it drives flits back to NIs on a valid-only channel (no ready).

Parameters:
GROUP_ID, 4, 4-bit group number owned by this switch (GPUs 13..16).
DATA_W, 16, flit width; header in bits [15:10].
IN_DEPTH, 4, per-input FIFO depth (power of 2, >=4).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
loc_in_data  in  4*DATA_W  flit from NI of leaf i at bits [i*16+:16]
loc_in_valid  in  4  per-leaf flit valid, 1-cycle pulse per flit
loc_in_ready  out  4  per-leaf permission for the NI to launch a flit next cycle
loc_out_data  out  4*DATA_W  flit to NI of leaf i
loc_out_valid  out  4  per-leaf valid, 1-cycle pulse, no backpressure
up_out_data  out  DATA_W  flit to group fabric
up_out_valid  out  1  uplink output valid
up_out_ready  in  1  uplink output ready
up_in_data  in  DATA_W  flit from group fabric
up_in_valid  in  1  uplink input valid
up_in_ready  out  1  uplink input ready
drop_cnt  out  8  saturating count of dropped flits

Behaviour:
- Reset (synchronous, active-high, clk edge): all FIFOs empty, all pointers 0, RR pointers 0, loc_out_valid=0, loc_out_data=0, up_out_valid=0, up_out_data=0, drop_cnt=0, loc_in_ready=4'b1111, up_in_ready=1. Reset mid-operation discards all buffered flits with no output activity afterward.
- Inputs: 5 FIFOs. Index 0..3 is local leaf i; index 4 is the uplink.
- Local input write: loc_in_valid[i]=1 writes the flit if FIFO i is not full. The write does not depend on ready, because the NI launches one cycle after sampling ready. If FIFO i is full, the flit is dropped and drop_cnt is incremented (saturates at 255).
- loc_in_ready[i] = (count_i <= IN_DEPTH-2), registered off the next-state count. This gives a 1-flit skid for the NI's 1-cycle launch latency.
- Uplink input: standard handshake. The flit is accepted when up_in_valid && up_in_ready; up_in_ready = !full4.
- Route decode on the FIFO head:
  - header[15:12]==GROUP_ID -> local output header[11:10].
  - Otherwise -> uplink output.
  - Uplink-sourced flits whose group != GROUP_ID are popped and dropped (drop_cnt++). They are never reflected to the uplink.
  - Local->local hairpin, including a leaf sending to itself, is legal.
- Data is forwarded unmodified; header translation belongs to the NI.
- Arbitration:
  - One round-robin arbiter per output (5), over the input heads requesting that output.
  - Priority starts at last_grant+1 mod 5. The pointer updates only on a grant.
  - At most one grant per output per cycle. Each input head goes to exactly one output, so it gets at most one grant.
- Local output i: registered. A grant loads loc_out_data[i] and sets loc_out_valid[i]=1 for exactly one cycle; valid is 0 in any cycle without a grant.
  - Local outputs are always grantable (no ready).
  - Back-to-back flits produce consecutive valid pulses.
- Uplink output: registered, valid/ready hold.
  - up_out_valid stays high and data stays stable until up_out_ready.
  - The uplink arbiter grants only when the register is empty or is being consumed in that cycle, so full throughput is 1 flit/cycle.
- Latency: input valid at edge t -> written at t; head visible cycle t+1; granted at t+1 edge; output valid at t+2 (minimum 2 cycles, no contention).
- Simultaneous push and pop on the same FIFO in one cycle: count unchanged. This is legal when full only if the pop occurs, in which case the push is not dropped.
- Pointer wrap: log2(IN_DEPTH)-bit pointers wrap naturally; count is log2(IN_DEPTH)+1 bits.
- Ordering is preserved per input->output pair. No ordering is guaranteed across inputs.

Test Plan:
1. Single flit, local hairpin: GROUP_ID=4, reset, leaf1 sends 0x4ABC. Required: loc_out_valid[2] high for 1 cycle exactly 2 cycles later, loc_out_data[2]=0x4ABC; no other output activity.
2. Uplink out with backpressure: leaf0 sends 0x8123 with up_out_ready=0 for 5 cycles. Required: up_out_valid=1 and data=0x8123 held stable until ready, then one transfer. A second flit, 0x8124, follows in the next cycle.
3. Contention and round-robin: leaf0, leaf1 and leaf2 each send 0x4C00, 0x4C01 and 0x4C02 in the same cycle, twice. Required: loc_out[3] delivers 0x4C00, 0x4C01, 0x4C02, 0x4C00, 0x4C01, 0x4C02 on consecutive cycles.
4. Skid/full: leaf3 pulses 0x4000 every cycle while output 0 is starved by continuous higher-priority traffic. Required: loc_in_ready[3] drops once count reaches 3. The flit launched in the next cycle is still stored (count 4). A further forced write is dropped and drop_cnt increments to 1.
5. Uplink misroute: up_in sends 0x9001. Required: it is accepted, then dropped; drop_cnt increments and no output activity occurs. up_in 0x4401 -> loc_out[1]=0x4401.
6. Reset mid-operation: 3 flits are buffered in FIFO0 (up_out_ready=0) and reset is asserted for 1 cycle. Required: all outputs 0, drop_cnt=0, ready signals high, and no stale flit appears after reset releases.
